// File: rtl/rr_packet_mux_pkg.sv
// -----------------------------------------------------------------------------
// rr_packet_mux_pkg
// Shared definitions for the round-robin packet multiplexer:
//   state_e  - two-state arbiter encoding (ST_IDLE / ST_BUSY)
//   sel_w()  - width of a grant/select index for a given requester count,
//              never less than one bit so SIZE=1 still has a legal vector
// -----------------------------------------------------------------------------
package rr_packet_mux_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Grant index width: (SIZE>1) ? $clog2(SIZE) : 1
  function automatic int sel_w(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

endpackage : rr_packet_mux_pkg

// File: rtl/rr_packet_mux_if.sv
// -----------------------------------------------------------------------------
// rr_packet_mux_if
// Bundles the requester lanes, the downstream channel and the status outputs
// of rr_packet_mux.
//   iValid/iLast/iData : SIZE producer lanes (lane i data at [i*WIDTH+:WIDTH])
//   oReady             : per-lane accept from the arbiter
//   oValid/oLast/oData : registered output beat
//   iReady             : downstream accept
//   oGrant/oBusy       : current owner index and packet-locked flag
// Modports:
//   master : the environment (producers + consumer)
//   slave  : the arbiter itself
// -----------------------------------------------------------------------------
interface rr_packet_mux_if #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 4
);
  import rr_packet_mux_pkg::*;

  localparam int SELW = sel_w(SIZE);

  logic [SIZE-1:0]       iValid;
  logic [SIZE-1:0]       iLast;
  logic [SIZE*WIDTH-1:0] iData;
  logic [SIZE-1:0]       oReady;
  logic                  oValid;
  logic                  oLast;
  logic [WIDTH-1:0]      oData;
  logic                  iReady;
  logic [SELW-1:0]       oGrant;
  logic                  oBusy;

  modport master (
    output iValid, iLast, iData, iReady,
    input  oReady, oValid, oLast, oData, oGrant, oBusy
  );

  modport slave (
    input  iValid, iLast, iData, iReady,
    output oReady, oValid, oLast, oData, oGrant, oBusy
  );

endinterface : rr_packet_mux_if

// File: rtl/rr_packet_mux_mux.sv
// -----------------------------------------------------------------------------
// Mux
// Plain combinational SIZE:1 data selector.
//   iSelect : index of the lane to forward
//   iData   : SIZE packed lanes, lane i at [i*WIDTH+:WIDTH]
//   oData   : selected lane; zero if iSelect is out of range
// -----------------------------------------------------------------------------
module Mux
  import rr_packet_mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SIZE  = 4
) (
  input  logic [sel_w(SIZE)-1:0] iSelect,
  input  logic [SIZE*WIDTH-1:0]  iData,
  output logic [WIDTH-1:0]       oData
);

  localparam int SELW = sel_w(SIZE);

  // One-hot style compare chain; unmatched (out-of-range) selects give zero
  always_comb begin
    oData = {WIDTH{1'b0}};
    for (int i = 0; i < SIZE; i++) begin
      oData = (iSelect == SELW'(i)) ? iData[i*WIDTH +: WIDTH] : oData;
    end
  end

endmodule : Mux

// File: rtl/rr_packet_mux.sv
// -----------------------------------------------------------------------------
// rr_packet_mux
// Round-robin arbiter that locks the shared output channel to one requester
// for a whole packet (until the beat carrying iLast transfers), then rotates
// priority to the requester after the one just served.
//   iClock   : rising-edge clock
//   iReset_n : asynchronous active-low reset
//   bus      : rr_packet_mux_if.slave - requester lanes, downstream channel,
//              oGrant (owner index) and oBusy (packet locked)
// The output beat is registered; oReady is combinational from the state
// registers and iReady so a downstream stall blocks the owner in-cycle.
// -----------------------------------------------------------------------------
module rr_packet_mux
  import rr_packet_mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SIZE  = 4
) (
  input  logic            iClock,
  input  logic            iReset_n,
  rr_packet_mux_if.slave  bus
);

  localparam int SELW = sel_w(SIZE);

  state_e           state_q;
  logic [SELW-1:0]  grant_q;
  logic [SELW-1:0]  ptr_q;
  logic             o_valid_q;
  logic             o_last_q;
  logic [WIDTH-1:0] o_data_q;

  logic [SELW-1:0]  pick_s;
  logic [SELW-1:0]  ptr_next_s;
  logic [WIDTH-1:0] mux_data_s;
  logic             slot_s;
  logic             own_valid_s;
  logic             own_last_s;
  logic             any_valid_s;
  logic [SIZE-1:0]  ready_s;

  // First requester at or after start, wrapping. The second pass only
  // matters when nothing at/after start is requesting, so its lowest hit is
  // exactly the wrapped winner.
  function automatic logic [SELW-1:0] rr_pick(
    input logic [SIZE-1:0] req,
    input logic [SELW-1:0] start
  );
    logic [SELW-1:0] sel;
    logic            found;
    logic            take;
    sel   = {SELW{1'b0}};
    found = 1'b0;
    for (int i = 0; i < SIZE; i++) begin
      take  = !found && req[i] && (SELW'(i) >= start);
      sel   = take ? SELW'(i) : sel;
      found = found | take;
    end
    for (int i = 0; i < SIZE; i++) begin
      take  = !found && req[i];
      sel   = take ? SELW'(i) : sel;
      found = found | take;
    end
    return sel;
  endfunction

  // Data path select is driven straight from the grant register
  Mux #(
    .WIDTH (WIDTH),
    .SIZE  (SIZE)
  ) u_mux (
    .iSelect (grant_q),
    .iData   (bus.iData),
    .oData   (mux_data_s)
  );

  // Arbitration candidate and rotated pointer after the current owner
  always_comb begin
    any_valid_s = |bus.iValid;
    pick_s      = rr_pick(bus.iValid, ptr_q);
    ptr_next_s  = (grant_q == SELW'(SIZE - 1)) ? {SELW{1'b0}} : grant_q + SELW'(1);
  end

  // Owner lane handshake view and per-lane ready
  always_comb begin
    slot_s      = !o_valid_q || bus.iReady;
    own_valid_s = 1'b0;
    own_last_s  = 1'b0;
    ready_s     = {SIZE{1'b0}};
    for (int i = 0; i < SIZE; i++) begin
      own_valid_s = own_valid_s | ((grant_q == SELW'(i)) & bus.iValid[i]);
      own_last_s  = own_last_s  | ((grant_q == SELW'(i)) & bus.iLast[i]);
      ready_s[i]  = (state_q == ST_BUSY) && (grant_q == SELW'(i)) && slot_s;
    end
  end

  // Arbiter FSM with the registered output beat
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= {SELW{1'b0}};
      ptr_q     <= {SELW{1'b0}};
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
      o_data_q  <= {WIDTH{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_valid_s) begin
            grant_q <= pick_s;
            state_q <= ST_BUSY;
          end
          // Drain the last beat of the previous packet once taken
          if (bus.iReady) begin
            o_valid_q <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (slot_s) begin
            if (own_valid_s) begin
              o_valid_q <= 1'b1;
              o_last_q  <= own_last_s;
              o_data_q  <= mux_data_s;
              if (own_last_s) begin
                state_q <= ST_IDLE;
                ptr_q   <= ptr_next_s;
              end
            end else begin
              // Owner bubble: slot is free but nothing to load; keep grant
              o_valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.oReady = ready_s;
  assign bus.oValid = o_valid_q;
  assign bus.oLast  = o_last_q;
  assign bus.oData  = o_data_q;
  assign bus.oGrant = grant_q;
  assign bus.oBusy  = (state_q == ST_BUSY);

endmodule : rr_packet_mux

// File: tb/tb_rr_packet_mux.sv
// -----------------------------------------------------------------------------
// tb_rr_packet_mux
// Directed bench for rr_packet_mux (WIDTH=32, SIZE=4). Producers are simple
// per-lane packet counters; lane i, packet p, beat b carries data
// {(i+1), p, b} packed as (i+1)<<12 | p<<4 | b. Each scenario task logs the
// DUT outputs every cycle and compares against hand-derived timelines.
// -----------------------------------------------------------------------------
module tb_rr_packet_mux;

  localparam int WIDTH = 32;
  localparam int SIZE  = 4;
  localparam int LOGN  = 128;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  rr_packet_mux_if #(.WIDTH(WIDTH), .SIZE(SIZE)) bus ();

  rr_packet_mux #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
    .iClock   (clk),
    .iReset_n (rst_n),
    .bus      (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  int num_pkts [SIZE];
  int pkt_len  [SIZE];
  int pkt_idx  [SIZE];
  int beat_idx [SIZE];

  int cyc;
  int stall_from, stall_to;
  int hold_req, hold_from, hold_to;

  logic             log_ovalid [LOGN];
  logic [WIDTH-1:0] log_odata  [LOGN];
  logic [SIZE-1:0]  log_oready [LOGN];
  logic [1:0]       log_grant  [LOGN];
  logic             log_busy   [LOGN];

  logic [WIDTH-1:0] out_data_q [$];
  logic             out_last_q [$];
  int               grant_order_q [$];
  logic             prev_busy;
  logic             last_ovalid;
  logic             last_busy;
  logic [WIDTH-1:0] last_odata;

  task automatic setup();
    for (int i = 0; i < SIZE; i++) begin
      num_pkts[i] = 0; pkt_len[i] = 1; pkt_idx[i] = 0; beat_idx[i] = 0;
    end
    cyc = 0;
    stall_from = -1; stall_to = -1;
    hold_req = -1; hold_from = -1; hold_to = -1;
    out_data_q.delete(); out_last_q.delete(); grant_order_q.delete();
    prev_busy = 1'b0;
  endtask

  task automatic drive_inputs();
    logic [SIZE-1:0]       v;
    logic [SIZE-1:0]       l;
    logic [SIZE*WIDTH-1:0] d;
    v = '0; l = '0; d = '0;
    for (int i = 0; i < SIZE; i++) begin
      v[i] = (pkt_idx[i] < num_pkts[i]) && !(i == hold_req && cyc >= hold_from && cyc <= hold_to);
      d[i*WIDTH +: WIDTH] = WIDTH'(((i + 1) << 12) | (pkt_idx[i] << 4) | beat_idx[i]);
      l[i] = (beat_idx[i] == pkt_len[i] - 1);
    end
    bus.iValid = v;
    bus.iLast  = l;
    bus.iData  = d;
    bus.iReady = !(cyc >= stall_from && cyc <= stall_to);
  endtask

  // Called just after a rising edge: drive, sample at the falling edge,
  // then advance producers on the handshakes seen in this cycle.
  task automatic step();
    logic [SIZE-1:0] hs;
    drive_inputs();
    @(negedge clk);
    if (cyc < LOGN) begin
      log_ovalid[cyc] = bus.oValid;
      log_odata[cyc]  = bus.oData;
      log_oready[cyc] = bus.oReady;
      log_grant[cyc]  = bus.oGrant;
      log_busy[cyc]   = bus.oBusy;
    end
    if (bus.oValid && bus.iReady) begin
      out_data_q.push_back(bus.oData);
      out_last_q.push_back(bus.oLast);
    end
    if (bus.oBusy && !prev_busy) grant_order_q.push_back(int'(bus.oGrant));
    prev_busy   = bus.oBusy;
    last_ovalid = bus.oValid;
    last_busy   = bus.oBusy;
    last_odata  = bus.oData;
    hs = bus.iValid & bus.oReady;
    @(posedge clk);
    #1;
    for (int i = 0; i < SIZE; i++) begin
      if (hs[i]) begin
        if (beat_idx[i] == pkt_len[i] - 1) begin
          beat_idx[i] = 0;
          pkt_idx[i]++;
        end else begin
          beat_idx[i]++;
        end
      end
    end
    cyc++;
  endtask

  function automatic bit producers_done();
    bit d;
    d = 1'b1;
    for (int i = 0; i < SIZE; i++) if (pkt_idx[i] < num_pkts[i]) d = 1'b0;
    return d;
  endfunction

  task automatic run_until_done(input string name, input int max_cycles);
    bit done;
    done = 1'b0;
    for (int c = 0; c < max_cycles && !done; c++) begin
      step();
      done = producers_done() && !last_ovalid && !last_busy;
    end
    n_total++;
    if (!done) $display("FAIL %s_drain: not drained after %0d cycles", name, max_cycles);
    else n_pass++;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.iValid = '0; bus.iLast = '0; bus.iData = '0; bus.iReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_stream(input string name, input logic [WIDTH-1:0] exp_d [$],
                              input logic exp_l [$]);
    n_total++;
    if (out_data_q.size() !== exp_d.size()) begin
      $display("FAIL %s_count: got %0d beats, expected %0d", name, out_data_q.size(), exp_d.size());
    end else begin
      n_pass++;
      for (int k = 0; k < exp_d.size(); k++) begin
        n_total++;
        if (out_data_q[k] !== exp_d[k])
          $display("FAIL %s_data[%0d]: got %h expected %h", name, k, out_data_q[k], exp_d[k]);
        else n_pass++;
        n_total++;
        if (out_last_q[k] !== exp_l[k])
          $display("FAIL %s_last[%0d]: got %b expected %b", name, k, out_last_q[k], exp_l[k]);
        else n_pass++;
      end
    end
  endtask

  task automatic check_grants(input string name, input int exp_g [$]);
    n_total++;
    if (grant_order_q.size() != exp_g.size()) begin
      $display("FAIL %s_grants: got %0d grants, expected %0d", name, grant_order_q.size(), exp_g.size());
    end else begin
      n_pass++;
      for (int k = 0; k < exp_g.size(); k++) begin
        n_total++;
        if (grant_order_q[k] != exp_g[k])
          $display("FAIL %s_grant[%0d]: got %0d expected %0d", name, k, grant_order_q[k], exp_g[k]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.iValid = 4'b1111; bus.iLast = 4'b0000; bus.iData = {SIZE{32'hDEAD_BEEF}}; bus.iReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_total++; if (bus.oValid !== 1'b0) $display("FAIL rst_oValid: got %b expected 0", bus.oValid); else n_pass++;
    n_total++; if (bus.oLast !== 1'b0) $display("FAIL rst_oLast: got %b expected 0", bus.oLast); else n_pass++;
    n_total++; if (bus.oData !== 32'h0) $display("FAIL rst_oData: got %h expected 0", bus.oData); else n_pass++;
    n_total++; if (bus.oReady !== 4'b0000) $display("FAIL rst_oReady: got %b expected 0000", bus.oReady); else n_pass++;
    n_total++; if (bus.oGrant !== 2'd0) $display("FAIL rst_oGrant: got %0d expected 0", bus.oGrant); else n_pass++;
    n_total++; if (bus.oBusy !== 1'b0) $display("FAIL rst_oBusy: got %b expected 0", bus.oBusy); else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_total++; if (bus.oBusy !== 1'b0) $display("FAIL rel_idle: got busy %b expected 0", bus.oBusy); else n_pass++;
    @(negedge clk);
    n_total++; if (bus.oBusy !== 1'b1) $display("FAIL rel_busy: got busy %b expected 1", bus.oBusy); else n_pass++;
    n_total++; if (bus.oGrant !== 2'd0) $display("FAIL rel_grant: got %0d expected 0", bus.oGrant); else n_pass++;
    n_total++; if (bus.oReady !== 4'b0001) $display("FAIL rel_ready: got %b expected 0001", bus.oReady); else n_pass++;
  endtask

  task automatic test_fairness();
    logic [WIDTH-1:0] exp_d [$];
    logic             exp_l [$];
    int               exp_g [$];
    apply_reset();
    setup();
    for (int i = 0; i < SIZE; i++) begin num_pkts[i] = 2; pkt_len[i] = 2; end
    run_until_done("fair", 80);
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < SIZE; i++) begin
        exp_g.push_back(i);
        for (int b = 0; b < 2; b++) begin
          exp_d.push_back(WIDTH'(((i + 1) << 12) | (p << 4) | b));
          exp_l.push_back(b == 1);
        end
      end
    end
    check_stream("fair", exp_d, exp_l);
    check_grants("fair", exp_g);
    // Each 2-beat packet: one IDLE cycle then two BUSY cycles
    for (int k = 0; k < 8; k++) begin
      n_total++;
      if ({log_busy[3*k], log_busy[3*k+1], log_busy[3*k+2]} !== 3'b011)
        $display("FAIL fair_busy_pattern[%0d]: got %b expected 011", k,
                 {log_busy[3*k], log_busy[3*k+1], log_busy[3*k+2]});
      else n_pass++;
    end
  endtask

  task automatic test_wrap_skip();
    apply_reset();
    setup();
    num_pkts[2] = 1; pkt_len[2] = 1;
    run_until_done("single", 20);
    check_stream("single", '{32'h0000_3000}, '{1'b1});
    n_total++;
    if ({log_busy[0], log_busy[1], log_busy[2]} !== 3'b010)
      $display("FAIL single_busy: got %b expected 010", {log_busy[0], log_busy[1], log_busy[2]});
    else n_pass++;
    setup();
    num_pkts[1] = 1; pkt_len[1] = 2;
    num_pkts[3] = 1; pkt_len[3] = 2;
    run_until_done("wrap", 30);
    check_grants("wrap", '{3, 1});
    check_stream("wrap", '{32'h0000_4000, 32'h0000_4001, 32'h0000_2000, 32'h0000_2001},
                 '{1'b0, 1'b1, 1'b0, 1'b1});
    // ptr should now be 2: with lanes 0 and 2 requesting, lane 2 wins first
    setup();
    num_pkts[0] = 1; num_pkts[2] = 1;
    run_until_done("ptr2", 20);
    check_grants("ptr2", '{2, 0});
  endtask

  task automatic test_backpressure();
    apply_reset();
    setup();
    num_pkts[0] = 1; pkt_len[0] = 4;
    stall_from = 4; stall_to = 6;
    run_until_done("bp", 30);
    n_total++; if (log_oready[1] !== 4'b0001) $display("FAIL bp_lat_ready: got %b expected 0001", log_oready[1]); else n_pass++;
    n_total++; if (log_ovalid[2] !== 1'b1) $display("FAIL bp_lat_valid: got %b expected 1", log_ovalid[2]); else n_pass++;
    n_total++; if (log_odata[2] !== 32'h0000_1000) $display("FAIL bp_lat_data: got %h expected 00001000", log_odata[2]); else n_pass++;
    for (int c = 4; c <= 6; c++) begin
      n_total++;
      if (log_ovalid[c] !== 1'b1 || log_odata[c] !== 32'h0000_1002)
        $display("FAIL bp_hold[%0d]: got valid %b data %h expected 1 00001002", c, log_ovalid[c], log_odata[c]);
      else n_pass++;
      n_total++;
      if (log_oready[c] !== 4'b0000)
        $display("FAIL bp_ready[%0d]: got %b expected 0000", c, log_oready[c]);
      else n_pass++;
    end
    check_stream("bp", '{32'h0000_1000, 32'h0000_1001, 32'h0000_1002, 32'h0000_1003},
                 '{1'b0, 1'b0, 1'b0, 1'b1});
  endtask

  task automatic test_bubble();
    apply_reset();
    setup();
    num_pkts[1] = 1; pkt_len[1] = 4;
    num_pkts[2] = 1; pkt_len[2] = 2;
    hold_req = 1; hold_from = 3; hold_to = 4;
    run_until_done("bub", 30);
    n_total++;
    if ({log_ovalid[3], log_ovalid[4], log_ovalid[5], log_ovalid[6]} !== 4'b1001)
      $display("FAIL bub_gap: got %b expected 1001",
               {log_ovalid[3], log_ovalid[4], log_ovalid[5], log_ovalid[6]});
    else n_pass++;
    for (int c = 1; c <= 6; c++) begin
      n_total++;
      if (log_grant[c] !== 2'd1 || log_oready[c][2] !== 1'b0)
        $display("FAIL bub_lock[%0d]: got grant %0d ready %b expected 1 with lane2 low", c, log_grant[c], log_oready[c]);
      else n_pass++;
    end
    check_grants("bub", '{1, 2});
    check_stream("bub", '{32'h0000_2000, 32'h0000_2001, 32'h0000_2002, 32'h0000_2003,
                          32'h0000_3000, 32'h0000_3001},
                 '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
  endtask

  task automatic test_reset_mid();
    bit hit;
    apply_reset();
    setup();
    num_pkts[2] = 1; pkt_len[2] = 1;
    run_until_done("pre", 20);
    setup();
    num_pkts[1] = 1; pkt_len[1] = 4;
    hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      step();
      hit = last_ovalid && (last_odata == 32'h0000_2001);
    end
    n_total++; if (!hit) $display("FAIL mid_reach: beat 2 not seen"); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if (bus.oValid !== 1'b0) $display("FAIL mid_oValid: got %b expected 0", bus.oValid); else n_pass++;
    n_total++; if (bus.oData !== 32'h0) $display("FAIL mid_oData: got %h expected 0", bus.oData); else n_pass++;
    n_total++; if (bus.oBusy !== 1'b0 || bus.oReady !== 4'b0000 || bus.oGrant !== 2'd0)
      $display("FAIL mid_ctrl: got busy %b ready %b grant %0d expected 0 0000 0", bus.oBusy, bus.oReady, bus.oGrant);
    else n_pass++;
    setup();
    drive_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    num_pkts[0] = 1; num_pkts[3] = 1;
    run_until_done("post", 20);
    check_grants("post", '{0, 3});
  endtask

  initial begin
    setup();
    test_reset();
    test_fairness();
    test_wrap_skip();
    test_backpressure();
    test_bubble();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_rr_packet_mux
